spi_slave_bridge_p: RTL and testbench
=====================================

// Module: spi_slave_bridge_p
// PURPOSE
// Parametrised SPI slave bridge: serial SPI pins <-> parallel DATA_W-bit words in the clk domain.
// Supports all four CPOL/CPHA modes, MSB- or LSB-first order, and valid/ready handshakes on both
// directions, plus underrun, overrun and abort status pulses. Sits between the external SPI master
// pins and the register/command logic, as the next-generation SPI front end.
// PARAMETERS
// DATA_W       8     word width in bits, 4..32
// CPOL         0     sclk idle level
// CPHA         0     0: sample on leading edge; 1: sample on trailing edge
// LSB_FIRST    0     1: shift LSB first, 0: MSB first (both directions)
// SYNC_STAGES  2     synchroniser flops on sclk/cs_n/mosi, >=2
// TX_IDLE      all-1 word sent on miso when no tx word is available (DATA_W bits)
// PORTS
// clk          in   1       system clock
// rst_n        in   1       asynchronous, active-low reset
// sclk         in   1       SPI clock from master (async)
// cs_n         in   1       SPI chip select, active low (async)
// mosi         in   1       SPI data in (async)
// miso         out  1       SPI data out; 1'bz whenever raw cs_n=1
// tx_data      in   DATA_W  next word to transmit
// tx_valid     in   1       tx_data valid
// tx_ready     out  1       holding register empty; transfer on tx_valid&tx_ready
// rx_data      out  DATA_W  last received word
// rx_valid     out  1       rx_data valid, held until rx_ready
// rx_ready     in   1       consumer accepts rx_data on rx_valid&rx_ready
// busy         out  1       synchronised cs_n active
// tx_underrun  out  1       1-clk pulse: word loaded from TX_IDLE
// rx_overrun   out  1       1-clk pulse: received word dropped
// word_abort   out  1       1-clk pulse: cs_n rose with partial word
// BEHAVIOUR
// - Reset: rx_data=0, rx_valid=0, tx_ready=1, busy=0, all pulses 0, shifters/bit_cnt=0, miso reg=0.
// - sclk/cs_n/mosi pass SYNC_STAGES flops; edges detected on sync'd sclk vs its previous value.
// - Leading edge = sclk leaving CPOL. Sample edge = rising if CPOL==CPHA, else falling; the other
//   edge is the shift edge. f_clk >= 8*f_sclk is required.
// - Edges are ignored while sync'd cs_n=1; in that state bit_cnt=0 and the rx shifter is held.
// - TX holding reg: tx_ready = !hold_full. Load event pulls hold into the tx shifter and frees
//   hold in the same clk. If hold is empty, TX_IDLE is loaded and tx_underrun pulses.
// - Load event, CPHA=0: sync'd cs_n falling edge, and the shift edge after the last sample of a
//   word. The first bit is driven on miso immediately.
// - Load event, CPHA=1: first shift edge of each word (bit_cnt==0); that edge drives the first bit.
// - Every other shift edge drives the next bit. The miso register holds between edges.
// - Sample edge: shift mosi into the rx shifter, bit_cnt++. At bit_cnt==DATA_W-1, wrap to 0 and
//   complete the word.
// - Word complete, rx_valid=0 (or rx_ready=1 that same clk): rx_data<=word, rx_valid=1 on the
//   next clk. Latency: the clk after the edge-detect clk.
// - Word complete while rx_valid=1 and rx_ready=0: keep old rx_data, drop the new word,
//   pulse rx_overrun.
// - Sync'd cs_n rising with bit_cnt!=0: discard the partial word, pulse word_abort, bit_cnt=0.
//   A tx word already loaded is lost and not re-queued.
// - tx_valid and a load event in the same clk: the load takes the old hold contents (or TX_IDLE),
//   then the new word is written into hold. No word is lost.
// - Reset mid-frame: everything returns to reset values. The bridge resynchronises on the next
//   cs_n assertion.
// TESTING
// 1 Mode0 W=8: tx 0xA5 queued, master sends 0x3C -> miso 10100101, rx_data=0x3C, 1 rx_valid, no underrun
// 2 CPOL=1,CPHA=1,W=16,LSB_FIRST=1: tx 0xBEEF, master 0x1234 -> miso LSB-first 0xBEEF, rx_data=0x1234
// 3 No tx_valid, 2-word frame -> miso 0xFF twice, tx_underrun pulses exactly 2x
// 4 rx_ready=0, words 0x11,0x22 -> rx_data stays 0x11, rx_overrun 1 pulse, after ready rx_valid=0
// 5 cs_n high after 5 bits -> word_abort 1 pulse, no rx_valid; next frame 0x5A received intact
// 6 rst_n low mid-word (bit 3) -> outputs at reset values; next frame 0xC3 exchanged correctly

Source files
------------

// File: rtl/spi_slave_bridge_p.sv
// ============================================================================
// Module   : spi_slave_bridge_p
// Function : SPI slave pins <-> DATA_W-bit valid/ready words in the clk domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_slave_bridge_p #(
    parameter int                DATA_W      = 8,
    parameter int                CPOL        = 0,
    parameter int                CPHA        = 0,
    parameter int                LSB_FIRST   = 0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              tx_underrun,
    output logic              rx_overrun,
    output logic              word_abort
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic              SCLK_IDL = (CPOL != 0);
    localparam logic              SAMPLE_R = (CPOL == CPHA);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      tx_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   miso_reg;
    logic [DATA_W-1:0]      hold_data;
    logic                   hold_full;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   load_evt;
    logic                   word_done;
    logic [DATA_W-1:0]      rx_word;
    logic [DATA_W-1:0]      load_word;

    // Synchronisers reset to the idle pin levels so reset release creates no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{SCLK_IDL}};
            cs_sync   <= {SYNC_STAGES{1'b1}};
            mosi_sync <= '0;
            sclk_prev <= SCLK_IDL;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        cs_s        = cs_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev;
        sclk_fall   = ~sclk_s & sclk_prev;
        cs_fall     = cs_prev & ~cs_s;
        cs_rise     = ~cs_prev & cs_s;
        sample_edge = ~cs_s & (SAMPLE_R ? sclk_rise : sclk_fall);
        shift_edge  = ~cs_s & (SAMPLE_R ? sclk_fall : sclk_rise);
        // A shift edge at bit_cnt==0 is the start of a word in either phase mode.
        load_evt    = (shift_edge & (bit_cnt == '0)) | ((CPHA == 0) & cs_fall);
        word_done   = sample_edge & (bit_cnt == LAST_BIT);
        load_word   = hold_full ? hold_data : TX_IDLE;
        if (LSB_FIRST != 0) begin
            rx_word = {mosi_s, rx_shift[DATA_W-1:1]};
        end else begin
            rx_word = {rx_shift[DATA_W-2:0], mosi_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (cs_s) begin
            bit_cnt  <= '0;
        end else if (sample_edge) begin
            rx_shift <= rx_word;
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            miso_reg    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load_evt) begin
                tx_underrun <= ~hold_full;
                if (LSB_FIRST != 0) begin
                    miso_reg <= load_word[0];
                    tx_shift <= load_word >> 1;
                end else begin
                    miso_reg <= load_word[DATA_W-1];
                    tx_shift <= load_word << 1;
                end
            end else if (shift_edge) begin
                if (LSB_FIRST != 0) begin
                    miso_reg <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                end else begin
                    miso_reg <= tx_shift[DATA_W-1];
                    tx_shift <= tx_shift << 1;
                end
            end
        end
    end

    // A write only happens while hold is empty, so a same-cycle load sees TX_IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end else if (load_evt) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            word_abort <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            word_abort <= cs_rise & (bit_cnt != '0);
            if (word_done) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = ~hold_full;
    assign busy     = ~cs_s;
    assign miso     = cs_n ? 1'bz : miso_reg;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_bridge_p.sv
// ============================================================================
// Module   : tb_spi_slave_bridge_p
// Function : Directed bench for spi_slave_bridge_p in mode 0 and mode 3 LSB-first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_bridge_p;

    localparam int HALF = 80;

    logic        clk;
    logic        rst_n;

    logic        sclk0, cs_n0, mosi0, tx_valid0, rx_ready0;
    wire         miso0;
    logic [7:0]  tx_data0, rx_data0;
    logic        tx_ready0, rx_valid0, busy0, tx_underrun0, rx_overrun0, word_abort0;

    logic        sclk1, cs_n1, mosi1, tx_valid1, rx_ready1;
    wire         miso1;
    logic [15:0] tx_data1, rx_data1;
    logic        tx_ready1, rx_valid1, busy1, tx_underrun1, rx_overrun1, word_abort1;

    int n_cmp;
    int n_err;
    int n_acc0, n_und0, n_ovr0, n_abt0;

    spi_slave_bridge_p #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .busy(busy0),
        .tx_underrun(tx_underrun0), .rx_overrun(rx_overrun0), .word_abort(word_abort0)
    );

    spi_slave_bridge_p #(.DATA_W(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .busy(busy1),
        .tx_underrun(tx_underrun1), .rx_overrun(rx_overrun1), .word_abort(word_abort1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_acc0 = 0; n_und0 = 0; n_ovr0 = 0; n_abt0 = 0;
    end

    always @(posedge clk) begin
        if (rx_valid0 && rx_ready0) n_acc0 <= n_acc0 + 1;
        if (tx_underrun0)           n_und0 <= n_und0 + 1;
        if (rx_overrun0)            n_ovr0 <= n_ovr0 + 1;
        if (word_abort0)            n_abt0 <= n_abt0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic queue0(input logic [7:0] d);
        @(negedge clk);
        tx_data0  = d;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
    endtask

    // Mode 0 master bits, MSB first; sclk is left high after the last bit.
    task automatic spi0_bits(input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (sclk0) sclk0 = 1'b0;
            mosi0 = mo[nbits-1-i];
            #HALF;
            mi[nbits-1-i] = miso0;
            sclk0 = 1'b1;
            #HALF;
        end
    endtask

    // cs_n rises before sclk returns low, so no trailing shift edge reaches the slave.
    task automatic frame0(input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        @(negedge clk);
        cs_n0 = 1'b0;
        #HALF;
        spi0_bits(nbits, mo, mi);
        cs_n0 = 1'b1;
        #HALF;
        sclk0 = 1'b0;
        #HALF;
    endtask

    // Mode 3 master, 16 bits LSB first.
    task automatic frame1(input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        @(negedge clk);
        cs_n1 = 1'b0;
        #HALF;
        for (int i = 0; i < 16; i++) begin
            sclk1 = 1'b0;
            mosi1 = mo[i];
            #HALF;
            mi[i] = miso1;
            sclk1 = 1'b1;
            #HALF;
        end
        cs_n1 = 1'b1;
        #(2 * HALF);
    endtask

    logic [15:0] mi;
    int          a0, u0, o0, b0;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sclk0 = 1'b0; cs_n0 = 1'b1; mosi0 = 1'b0; tx_valid0 = 1'b0; tx_data0 = '0; rx_ready0 = 1'b1;
        sclk1 = 1'b1; cs_n1 = 1'b1; mosi1 = 1'b0; tx_valid1 = 1'b0; tx_data1 = '0; rx_ready1 = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_rx_data", 32'(rx_data0), 32'h0);
        check("rst_rx_valid", 32'(rx_valid0), 32'h0);
        check("rst_tx_ready", 32'(tx_ready0), 32'h1);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_underrun", 32'(tx_underrun0), 32'h0);
        check("rst_overrun", 32'(rx_overrun0), 32'h0);
        check("rst_abort", 32'(word_abort0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: mode 0 single word
        u0 = n_und0; a0 = n_acc0;
        queue0(8'hA5);
        check("t1_tx_ready_full", 32'(tx_ready0), 32'h0);
        frame0(8, 16'h003C, mi);
        check("t1_miso", 32'(mi[7:0]), 32'hA5);
        check("t1_rx_data", 32'(rx_data0), 32'h3C);
        check("t1_rx_count", 32'(n_acc0 - a0), 32'd1);
        check("t1_underrun", 32'(n_und0 - u0), 32'd0);
        check("t1_tx_ready", 32'(tx_ready0), 32'h1);

        // 2: mode 3, 16-bit LSB first
        @(negedge clk);
        tx_data1  = 16'hBEEF;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        frame1(16'h1234, mi);
        check("t2_miso", 32'(mi), 32'hBEEF);
        check("t2_rx_data", 32'(rx_data1), 32'h1234);

        // 3: two-word frame with nothing queued
        u0 = n_und0;
        frame0(16, 16'h0000, mi);
        check("t3_miso_w0", 32'(mi[15:8]), 32'hFF);
        check("t3_miso_w1", 32'(mi[7:0]), 32'hFF);
        check("t3_underrun", 32'(n_und0 - u0), 32'd2);

        // 4: overrun with consumer stalled
        o0 = n_ovr0;
        @(negedge clk);
        rx_ready0 = 1'b0;
        frame0(16, 16'h1122, mi);
        check("t4_rx_data", 32'(rx_data0), 32'h11);
        check("t4_rx_valid", 32'(rx_valid0), 32'h1);
        check("t4_overrun", 32'(n_ovr0 - o0), 32'd1);
        @(negedge clk);
        rx_ready0 = 1'b1;
        @(negedge clk);
        check("t4_rx_valid_clr", 32'(rx_valid0), 32'h0);

        // 5: abort after 5 bits, then a clean frame
        b0 = n_abt0; a0 = n_acc0;
        frame0(5, 16'h0015, mi);
        check("t5_abort", 32'(n_abt0 - b0), 32'd1);
        check("t5_no_rx", 32'(n_acc0 - a0), 32'd0);
        frame0(8, 16'h005A, mi);
        check("t5_rx_data", 32'(rx_data0), 32'h5A);
        check("t5_rx_count", 32'(n_acc0 - a0), 32'd1);

        // 6: reset mid-word
        queue0(8'h77);
        @(negedge clk);
        cs_n0 = 1'b0;
        #HALF;
        check("t6_busy", 32'(busy0), 32'h1);
        spi0_bits(3, 16'h0005, mi);
        queue0(8'h99);
        check("t6_hold_full", 32'(tx_ready0), 32'h0);
        rst_n = 1'b0;
        cs_n0 = 1'b1;
        sclk0 = 1'b0;
        #30;
        check("t6_rst_rx_data", 32'(rx_data0), 32'h0);
        check("t6_rst_rx_valid", 32'(rx_valid0), 32'h0);
        check("t6_rst_tx_ready", 32'(tx_ready0), 32'h1);
        check("t6_rst_busy", 32'(busy0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        queue0(8'hC3);
        frame0(8, 16'h00C3, mi);
        check("t6_miso", 32'(mi[7:0]), 32'hC3);
        check("t6_rx_data", 32'(rx_data0), 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
